// File: rtl/step_profile_gen.sv
// Trapezoidal step-profile generator: turns move commands into accel/cruise/decel spaced
// step strobes and drives the sequencer enable with a post-move hold window.
module step_profile_gen #(
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned DIV_W     = 16,
   parameter int unsigned START_DIV = 8,
   parameter int unsigned MIN_DIV   = 4,
   parameter int unsigned ACC_DEC   = 2,
   parameter int unsigned HOLD_CYC  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_dir,
   input  logic             cmd_half,
   input  logic [CNT_W-1:0] cmd_steps,
   input  logic             stop,
   output logic             step_pulse,
   output logic             dir,
   output logic             half_step,
   output logic             turn_on,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] steps_left
);

   localparam int unsigned HoldW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
   localparam logic [DIV_W-1:0] StartDiv = DIV_W'(START_DIV);
   localparam logic [DIV_W-1:0] MinDiv   = DIV_W'(MIN_DIV);
   localparam logic [DIV_W-1:0] AccDec   = DIV_W'(ACC_DEC);
   localparam logic [HoldW-1:0] HoldMax  = HoldW'(HOLD_CYC);

   typedef enum logic [2:0] {StIdle, StAccel, StCruise, StDecel, StHold} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [CNT_W-1:0] ramp_q, ramp_d;
   logic [DIV_W-1:0] period_q, period_d;
   logic [DIV_W-1:0] timer_q, timer_d;
   logic [HoldW-1:0] hold_q, hold_d;
   logic             dir_q, dir_d;
   logic             half_q, half_d;
   logic             pulse_q, pulse_d;
   logic             pend_q, pend_d;
   logic             done_q, done_d;

   logic             accept;
   logic [DIV_W:0]   up_sum;
   logic [DIV_W:0]   dn_floor;
   logic [DIV_W-1:0] period_up;
   logic [DIV_W-1:0] period_dn;
   logic [CNT_W-1:0] rem_n;
   logic [CNT_W-1:0] ramp_up;
   logic [CNT_W-1:0] ramp_dn;
   logic [CNT_W:0]   stop_lim;

   assign cmd_ready  = (state_q == StIdle) || (state_q == StHold);
   assign busy       = (state_q == StAccel) || (state_q == StCruise) || (state_q == StDecel);
   assign turn_on    = (state_q != StIdle);
   assign accept     = cmd_valid && cmd_ready;
   assign step_pulse = pulse_q;
   assign dir        = dir_q;
   assign half_step  = half_q;
   assign done       = done_q;
   assign steps_left = rem_q;

   // Saturating period arithmetic, widened by one bit so the clamps cannot wrap.
   assign up_sum    = {1'b0, period_q} + {1'b0, AccDec};
   assign dn_floor  = {1'b0, MinDiv} + {1'b0, AccDec};
   assign period_up = (up_sum > {1'b0, StartDiv}) ? StartDiv : up_sum[DIV_W-1:0];
   assign period_dn = ({1'b0, period_q} < dn_floor) ? MinDiv : (period_q - AccDec);
   assign rem_n     = (rem_q == '0) ? '0 : (rem_q - CNT_W'(1));
   assign ramp_up   = (&ramp_q) ? ramp_q : (ramp_q + CNT_W'(1));
   assign ramp_dn   = (ramp_q == '0) ? '0 : (ramp_q - CNT_W'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         rem_q    <= '0;
         ramp_q   <= '0;
         period_q <= '0;
         timer_q  <= '0;
         hold_q   <= '0;
         dir_q    <= 1'b0;
         half_q   <= 1'b0;
         pulse_q  <= 1'b0;
         pend_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         ramp_q   <= ramp_d;
         period_q <= period_d;
         timer_q  <= timer_d;
         hold_q   <= hold_d;
         dir_q    <= dir_d;
         half_q   <= half_d;
         pulse_q  <= pulse_d;
         pend_q   <= pend_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      ramp_d   = ramp_q;
      period_d = period_q;
      timer_d  = timer_q;
      hold_d   = hold_q;
      dir_d    = dir_q;
      half_d   = half_q;
      pulse_d  = 1'b0;
      pend_d   = 1'b0;
      done_d   = pend_q;
      stop_lim = '0;

      case (state_q)
         StIdle, StHold: begin
            if (state_q == StHold) begin
               if (hold_q == HoldMax) begin
                  state_d = StIdle;
                  hold_d  = '0;
               end else begin
                  hold_d = hold_q + HoldW'(1);
               end
            end
            if (accept) begin
               dir_d  = cmd_dir;
               half_d = cmd_half;
               if (cmd_steps == '0) begin
                  // Empty move: acknowledge with done, leave state and hold timing alone.
                  rem_d  = '0;
                  done_d = 1'b1;
               end else begin
                  state_d  = StAccel;
                  rem_d    = cmd_steps;
                  period_d = StartDiv;
                  ramp_d   = '0;
                  timer_d  = StartDiv;
                  hold_d   = '0;
               end
            end
         end
         default: begin
            if (timer_q <= DIV_W'(1)) begin
               pulse_d = 1'b1;
               rem_d   = rem_n;
               if (rem_n == '0) begin
                  state_d = (HOLD_CYC == 0) ? StIdle : StHold;
                  pend_d  = 1'b1;
                  hold_d  = '0;
               end else if ((state_q != StDecel) && (rem_n <= ramp_q)) begin
                  state_d  = StDecel;
                  period_d = period_up;
                  ramp_d   = ramp_dn;
               end else if (state_q == StAccel) begin
                  period_d = period_dn;
                  ramp_d   = ramp_up;
                  if (period_dn == MinDiv) state_d = StCruise;
               end else if (state_q == StDecel) begin
                  period_d = period_up;
                  ramp_d   = ramp_dn;
               end
               timer_d = (rem_n == '0) ? '0 : period_d;
            end else begin
               timer_d = timer_q - DIV_W'(1);
            end
            // Controlled stop: keep just enough steps to ramp back down to START_DIV.
            if (stop && (state_q != StDecel) &&
                ((state_d == StAccel) || (state_d == StCruise))) begin
               stop_lim = {1'b0, ramp_d} + {{CNT_W{1'b0}}, 1'b1};
               if ({1'b0, rem_d} > stop_lim) rem_d = stop_lim[CNT_W-1:0];
               state_d = StDecel;
            end
         end
      endcase
   end

endmodule

// File: tb/tb_step_profile_gen.sv
// Directed self-checking bench for step_profile_gen with hand-derived pulse spacing.
module tb_step_profile_gen;

   localparam int unsigned CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_dir = 1'b0;
   logic             cmd_half = 1'b0;
   logic             stop = 1'b0;
   logic [CNT_W-1:0] cmd_steps = '0;
   logic             cmd_ready, step_pulse, dir, half_step, turn_on, busy, done;
   logic [CNT_W-1:0] steps_left;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   step_profile_gen #(
      .CNT_W    (CNT_W),
      .DIV_W    (16),
      .START_DIV(8),
      .MIN_DIV  (4),
      .ACC_DEC  (2),
      .HOLD_CYC (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_dir   (cmd_dir),
      .cmd_half  (cmd_half),
      .cmd_steps (cmd_steps),
      .stop      (stop),
      .step_pulse(step_pulse),
      .dir       (dir),
      .half_step (half_step),
      .turn_on   (turn_on),
      .busy      (busy),
      .done      (done),
      .steps_left(steps_left)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Returns at the negedge just after the accept edge.
   task automatic send(input logic d, input logic h, input int s);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_dir   = d;
      cmd_half  = h;
      cmd_steps = CNT_W'(s);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Cycles until the next step_pulse (-1 on timeout) and how many of them had turn_on low.
   task automatic wait_pulse(output int n, output int off);
      n   = -1;
      off = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (!turn_on) off++;
         if (step_pulse) begin
            n = i;
            break;
         end
      end
   endtask

   // Called at the negedge of the final pulse.
   task automatic finish_chk(input string tag);
      chk({tag, "_done_at_pulse"}, 32'(done), 0);
      chk({tag, "_busy_at_last"}, 32'(busy), 0);
      @(negedge clk);
      chk({tag, "_done"}, 32'(done), 1);
      chk({tag, "_left0"}, 32'(steps_left), 0);
      @(negedge clk);
      chk({tag, "_done_once"}, 32'(done), 0);
      repeat (2) @(negedge clk);
      chk({tag, "_hold_on"}, 32'(turn_on), 1);
      @(negedge clk);
      chk({tag, "_turn_off"}, 32'(turn_on), 0);
      chk({tag, "_ready"}, 32'(cmd_ready), 1);
   endtask

   initial begin
      int n, off, cnt_p, cnt_on, cnt_d;
      int exp2[3];
      int exp3[10];
      exp2 = '{8, 6, 8};
      exp3 = '{8, 6, 4, 4, 4, 4, 4, 4, 6, 8};

      // Reset state
      #1;
      chk("rst_ready", 32'(cmd_ready), 1);
      chk("rst_turn_on", 32'(turn_on), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_pulse", 32'(step_pulse), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_left", 32'(steps_left), 0);
      chk("rst_dir", 32'(dir), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Three-step move: 8,6,8
      send(1'b1, 1'b1, 3);
      chk("t2_dir", 32'(dir), 1);
      chk("t2_half", 32'(half_step), 1);
      chk("t2_busy", 32'(busy), 1);
      chk("t2_on", 32'(turn_on), 1);
      chk("t2_left", 32'(steps_left), 3);
      for (int k = 0; k < 3; k++) begin
         wait_pulse(n, off);
         chk("t2_interval", n, exp2[k]);
      end
      finish_chk("t2");

      // Ten-step move through cruise; dir input toggled mid-move must not leak through
      send(1'b0, 1'b0, 10);
      cmd_dir = 1'b1;
      chk("t3_left_start", 32'(steps_left), 10);
      for (int k = 0; k < 10; k++) begin
         wait_pulse(n, off);
         chk("t3_interval", n, exp3[k]);
         chk("t3_left", 32'(steps_left), 32'(9 - k));
         chk("t3_dir_stable", 32'(dir), 0);
         if (k < 9) chk("t3_busy", 32'(busy), 1);
      end
      finish_chk("t3");

      // Long move, stop requested during cruise
      send(1'b1, 1'b0, 100);
      for (int k = 0; k < 3; k++) begin
         wait_pulse(n, off);
         chk("t4_interval", n, exp2[k] == 8 && k == 2 ? 4 : (k == 0 ? 8 : 6));
      end
      chk("t4_left97", 32'(steps_left), 97);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("t4_left_clamp", 32'(steps_left), 3);
      chk("t4_busy", 32'(busy), 1);
      wait_pulse(n, off);
      chk("t4_stop_int4", n + 1, 4);
      chk("t4_left2", 32'(steps_left), 2);
      wait_pulse(n, off);
      chk("t4_stop_int6", n, 6);
      chk("t4_left1", 32'(steps_left), 1);
      wait_pulse(n, off);
      chk("t4_stop_int8", n, 8);
      finish_chk("t4");
      repeat (2) @(negedge clk);
      chk("t4_no_wrap", 32'(steps_left), 0);

      // Zero-step command
      send(1'b0, 1'b0, 0);
      chk("t5_done", 32'(done), 1);
      chk("t5_on", 32'(turn_on), 0);
      chk("t5_busy", 32'(busy), 0);
      cnt_p  = 0;
      cnt_on = 0;
      cnt_d  = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (step_pulse) cnt_p++;
         if (turn_on) cnt_on++;
         if (done) cnt_d++;
      end
      chk("t5_pulses", cnt_p, 0);
      chk("t5_on_cycles", cnt_on, 0);
      chk("t5_extra_done", cnt_d, 0);

      // Back-to-back: new command accepted during hold with flipped direction
      send(1'b0, 1'b0, 3);
      for (int k = 0; k < 3; k++) wait_pulse(n, off);
      @(negedge clk);
      chk("t6_done", 32'(done), 1);
      chk("t6_hold_on", 32'(turn_on), 1);
      chk("t6_dir_before", 32'(dir), 0);
      send(1'b1, 1'b1, 2);
      chk("t6_dir_after", 32'(dir), 1);
      chk("t6_half_after", 32'(half_step), 1);
      chk("t6_on", 32'(turn_on), 1);
      chk("t6_busy", 32'(busy), 1);
      chk("t6_left", 32'(steps_left), 2);
      wait_pulse(n, off);
      chk("t6_first_int", n, 8);
      chk("t6_on_gaps", off, 0);
      wait_pulse(n, off);
      chk("t6_second_int", n, 6);
      @(negedge clk);
      chk("t6_done2", 32'(done), 1);
      repeat (6) @(negedge clk);
      chk("t6_idle", 32'(turn_on), 0);

      // Asynchronous reset in the middle of cruise
      send(1'b1, 1'b1, 50);
      for (int k = 0; k < 4; k++) wait_pulse(n, off);
      chk("t1_busy_pre", 32'(busy), 1);
      #2;
      rst = 1'b0;
      #1;
      chk("t1_on", 32'(turn_on), 0);
      chk("t1_busy", 32'(busy), 0);
      chk("t1_ready", 32'(cmd_ready), 1);
      chk("t1_left", 32'(steps_left), 0);
      chk("t1_pulse", 32'(step_pulse), 0);
      chk("t1_dir", 32'(dir), 0);
      chk("t1_half", 32'(half_step), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      cnt_p = 0;
      cnt_on = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (step_pulse) cnt_p++;
         if (turn_on) cnt_on++;
      end
      chk("t1_no_pulses", cnt_p, 0);
      chk("t1_stays_off", cnt_on, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
